// File: rtl/toggle_event_receiver.sv
// Toggle-line event receiver: synchronizes a T flip-flop line, turns each level
// change into an event, queues up to 15 pending events and flags idle timeouts.
module toggle_event_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       T,
    input  logic       EN,
    input  logic       EVT_READY,
    input  logic       CLR_OVF,
    output logic       PULSE,
    output logic       EVT_VALID,
    output logic [3:0] PEND,
    output logic       OVF,
    output logic       TIMEOUT
);

    typedef enum logic [1:0] {ARM, IDLE, ACTIVE, TOUT} state_t;

    localparam int          ACW   = $clog2(SYNC_STAGES + 1);
    localparam logic [15:0] TMO16 = 16'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ref_q;
    logic                   pulse_q;
    logic [3:0]             pend_q, pend_d;
    logic                   ovf_q, ovf_d;
    logic [15:0]            timer_q, timer_d;
    logic [ACW-1:0]         arm_q, arm_d;
    state_t                 state_q, state_d;

    logic det, acc, pop;

    // ARM masks detection until the chain and REF have absorbed the line level
    assign det = (sync_q[SYNC_STAGES-1] != ref_q) && (state_q != ARM);
    assign acc = det && EN;
    assign pop = (pend_q != 4'd0) && EVT_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q  <= '0;
            ref_q   <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= 4'd0;
            ovf_q   <= 1'b0;
            timer_q <= 16'd0;
            arm_q   <= '0;
            state_q <= ARM;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], T};
            ref_q   <= sync_q[SYNC_STAGES-1];
            pulse_q <= acc;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            timer_q <= timer_d;
            arm_q   <= arm_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        arm_d   = arm_q;
        case (state_q)
            ARM: begin
                if (arm_q == ACW'(SYNC_STAGES)) state_d = IDLE;
                else                            arm_d   = arm_q + 1'b1;
            end
            IDLE: begin
                if (acc) begin
                    state_d = ACTIVE;
                    timer_d = 16'd0;
                end
            end
            ACTIVE: begin
                if (acc) begin
                    timer_d = 16'd0;
                end else if (EN) begin
                    timer_d = timer_q + 16'd1;
                    if (timer_q + 16'd1 == TMO16) state_d = TOUT;
                end
            end
            TOUT: begin
                if (acc) begin
                    state_d = ACTIVE;
                    timer_d = 16'd0;
                end
            end
            default: state_d = ARM;
        endcase
    end

    // A saturating push only sets OVF when no pop frees a slot the same edge
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q & ~CLR_OVF;
        if (acc && !pop) begin
            if (pend_q == 4'hF) ovf_d  = 1'b1;
            else                pend_d = pend_q + 4'd1;
        end else if (!acc && pop) begin
            pend_d = pend_q - 4'd1;
        end
    end

    assign PULSE     = pulse_q;
    assign EVT_VALID = (pend_q != 4'd0);
    assign PEND      = pend_q;
    assign OVF       = ovf_q;
    assign TIMEOUT   = (state_q == TOUT);

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver: a per-cycle vector table plus
// hand-written sequences for arming, saturation, timeout and mid-stream reset.
module tb_toggle_event_receiver;

    logic       CLK = 1'b0;
    logic       RST, T, EN, EVT_READY, CLR_OVF;
    logic       PULSE, EVT_VALID, OVF, TIMEOUT;
    logic [3:0] PEND;

    int checks = 0;
    int errors = 0;
    int npulse;

    toggle_event_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYC(10)) dut (
        .CLK(CLK), .RST(RST), .T(T), .EN(EN), .EVT_READY(EVT_READY),
        .CLR_OVF(CLR_OVF), .PULSE(PULSE), .EVT_VALID(EVT_VALID),
        .PEND(PEND), .OVF(OVF), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       t, en, rdy, clr;
        logic       pulse;
        logic [3:0] pend;
        logic       valid, ovf, tout;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic t, en, rdy, clr, pulse,
                                input logic [3:0] pend, input logic valid, ovf, tout);
        vec_t v;
        v.t = t; v.en = en; v.rdy = rdy; v.clr = clr;
        v.pulse = pulse; v.pend = pend; v.valid = valid; v.ovf = ovf; v.tout = tout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (PULSE === 1'b1) npulse++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pulse"}, 16'(PULSE), 16'd0);
        chk({tag, " valid"}, 16'(EVT_VALID), 16'd0);
        chk({tag, " pend"}, 16'(PEND), 16'd0);
        chk({tag, " ovf"}, 16'(OVF), 16'd0);
        chk({tag, " timeout"}, 16'(TIMEOUT), 16'd0);
    endtask

    initial begin
        RST = 1'b1; T = 1'b1; EN = 1'b1; EVT_READY = 1'b0; CLR_OVF = 1'b0;
        npulse = 0;

        //               t  en rdy clr | pls pend val ovf tout
        tbl[0]  = mk(0, 1, 0, 0, 0, 4'd0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 4'd0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 1, 4'd1, 1, 0, 0);
        tbl[3]  = mk(1, 1, 0, 0, 0, 4'd1, 1, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 4'd1, 1, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 1, 4'd2, 1, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 1, 4'd3, 1, 0, 0);
        tbl[7]  = mk(0, 1, 1, 0, 0, 4'd2, 1, 0, 0);
        tbl[8]  = mk(1, 1, 1, 0, 0, 4'd1, 1, 0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 4'd1, 1, 0, 0);
        tbl[10] = mk(1, 1, 1, 0, 1, 4'd1, 1, 0, 0);
        tbl[11] = mk(1, 1, 1, 0, 0, 4'd0, 0, 0, 0);
        tbl[12] = mk(1, 1, 1, 1, 0, 4'd0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
        tbl[16] = mk(0, 1, 0, 0, 0, 4'd0, 0, 0, 0);

        // Reset with T held high; release must not produce an event
        repeat (3) tick();
        chk_all_zero("in_reset");
        RST = 1'b0;
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("arm%0d pulse", i), 16'(PULSE), 16'd0);
            chk($sformatf("arm%0d pend", i), 16'(PEND), 16'd0);
        end

        // Per-cycle vector table
        for (int i = 0; i < 17; i++) begin
            T = tbl[i].t; EN = tbl[i].en; EVT_READY = tbl[i].rdy; CLR_OVF = tbl[i].clr;
            tick();
            chk($sformatf("row%0d pulse", i), 16'(PULSE), 16'(tbl[i].pulse));
            chk($sformatf("row%0d pend", i), 16'(PEND), 16'(tbl[i].pend));
            chk($sformatf("row%0d valid", i), 16'(EVT_VALID), 16'(tbl[i].valid));
            chk($sformatf("row%0d ovf", i), 16'(OVF), 16'(tbl[i].ovf));
            chk($sformatf("row%0d timeout", i), 16'(TIMEOUT), 16'(tbl[i].tout));
        end
        CLR_OVF = 1'b0;

        // Five toggles 4 cycles apart, 3-edge latency, single-cycle strobes
        EVT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            T = ~T;
            tick(); chk($sformatf("tog%0d e1", i), 16'(PULSE), 16'd0);
            tick(); chk($sformatf("tog%0d e2", i), 16'(PULSE), 16'd0);
            tick(); chk($sformatf("tog%0d e3", i), 16'(PULSE), 16'd1);
            tick(); chk($sformatf("tog%0d e4", i), 16'(PULSE), 16'd0);
        end
        chk("five pend", 16'(PEND), 16'd5);
        chk("five valid", 16'(EVT_VALID), 16'd1);
        EVT_READY = 1'b1;
        repeat (5) tick();
        chk("five drained", 16'(PEND), 16'd0);

        // Timeout exactly 10 cycles after the pulse, dropped with the next pulse
        T = ~T;
        tick(); tick(); tick();
        chk("tmo pulse", 16'(PULSE), 16'd1);
        chk("tmo at pulse", 16'(TIMEOUT), 16'd0);
        for (int i = 1; i < 10; i++) begin
            tick();
            chk($sformatf("tmo early%0d", i), 16'(TIMEOUT), 16'd0);
        end
        tick(); chk("tmo at 10", 16'(TIMEOUT), 16'd1);
        tick(); tick(); chk("tmo held", 16'(TIMEOUT), 16'd1);
        T = ~T;
        tick(); tick(); chk("tmo before evt", 16'(TIMEOUT), 16'd1);
        tick();
        chk("tmo exit pulse", 16'(PULSE), 16'd1);
        chk("tmo exit", 16'(TIMEOUT), 16'd0);
        tick();
        EVT_READY = 1'b0;

        // Saturation: 17 events with no consumer
        npulse = 0;
        for (int i = 0; i < 17; i++) begin
            T = ~T;
            tick(); tick();
        end
        repeat (3) tick();
        chk("sat pulses", 16'(npulse), 16'd17);
        chk("sat pend", 16'(PEND), 16'd15);
        chk("sat ovf", 16'(OVF), 16'd1);
        CLR_OVF = 1'b1; tick(); CLR_OVF = 1'b0;
        chk("clr ovf", 16'(OVF), 16'd0);
        chk("clr pend", 16'(PEND), 16'd15);

        // Overflowing push beats a simultaneous clear
        T = ~T;
        tick(); tick();
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        chk("race pulse", 16'(PULSE), 16'd1);
        chk("race ovf", 16'(OVF), 16'd1);
        chk("race pend", 16'(PEND), 16'd15);
        CLR_OVF = 1'b1; tick(); CLR_OVF = 1'b0;
        chk("race clr", 16'(OVF), 16'd0);

        // Push and pop together at saturation, then drain
        T = ~T;
        tick(); tick();
        EVT_READY = 1'b1;
        tick();
        chk("pp pulse", 16'(PULSE), 16'd1);
        chk("pp pend", 16'(PEND), 16'd15);
        chk("pp ovf", 16'(OVF), 16'd0);
        repeat (14) tick();
        chk("drain14 pend", 16'(PEND), 16'd1);
        tick();
        chk("drain pend", 16'(PEND), 16'd0);
        chk("drain valid", 16'(EVT_VALID), 16'd0);
        EVT_READY = 1'b0;

        // Disabled toggles are dropped; the next enabled one counts once
        EN = 1'b0;
        npulse = 0;
        for (int i = 0; i < 3; i++) begin
            T = ~T;
            repeat (3) tick();
        end
        repeat (2) tick();
        chk("dis pulses", 16'(npulse), 16'd0);
        chk("dis pend", 16'(PEND), 16'd0);
        EN = 1'b1;
        tick();
        T = ~T;
        repeat (5) tick();
        chk("en pulses", 16'(npulse), 16'd1);
        chk("en pend", 16'(PEND), 16'd1);

        // Asynchronous reset mid-stream
        T = ~T;
        tick();
        #1 RST = 1'b1;
        #1 chk_all_zero("async_rst");
        tick();
        chk_all_zero("rst_held");
        RST = 1'b0;
        npulse = 0;
        repeat (6) tick();
        chk("post_rst pulses", 16'(npulse), 16'd0);
        chk("post_rst pend", 16'(PEND), 16'd0);
        T = ~T;
        tick(); tick(); tick();
        chk("post_rst pulse", 16'(PULSE), 16'd1);
        chk("post_rst pend1", 16'(PEND), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_event_receiver.md
TOGGLE_EVENT_RECEIVER -- requirements
Module: toggle_event_receiver

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (min 2).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 255, idle cycles after the last event before TIMEOUT asserts (1..65535).
REQ-003 The block SHALL have port CLK  input  1  single clock, rising edge active.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port T  input  1  toggle line from the transmitting T flip-flop; each level change is one event; asynchronous to CLK.
REQ-006 The block SHALL have port EN  input  1  event enable.
REQ-007 The block SHALL have port EVT_READY  input  1  consumer accepts one pending event.
REQ-008 The block SHALL have port CLR_OVF  input  1  clears OVF.
REQ-009 The block SHALL have port PULSE  output  1  one-cycle strobe per accepted event.
REQ-010 The block SHALL have port EVT_VALID  output  1  high when PEND > 0.
REQ-011 The block SHALL have port PEND  output  4  count of pending unconsumed events.
REQ-012 The block SHALL have port OVF  output  1  sticky, an event was lost at saturation.
REQ-013 The block SHALL have port TIMEOUT  output  1  no event for TIMEOUT_CYC cycles while ACTIVE.

Function
REQ-014 The block SHALL sample T through a SYNC_STAGES-deep flop chain, plus one reference-level register REF.
REQ-015 An event SHALL be detected when the synchronized T differs from REF; REF SHALL load the synchronized value every cycle.
REQ-016 A level change on T meeting setup before rising edge k SHALL assert PULSE in the cycle after edge k+SYNC_STAGES (3-edge latency with default parameters).
REQ-017 With EN=0, detected events SHALL be discarded: no PULSE, no PEND change, timer frozen; REF still tracks.
REQ-018 A push SHALL occur on an accepted event; a pop SHALL occur when EVT_VALID=1 and EVT_READY=1 at a rising edge.
REQ-019 PEND SHALL update as: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-020 At PEND=15, a push without a pop SHALL leave PEND=15 and set OVF; a push with a pop SHALL leave PEND=15 and not set OVF.
REQ-021 EVT_READY with PEND=0 SHALL be ignored.
REQ-022 CLR_OVF=1 SHALL clear OVF at the next edge; an OVF-setting push in the same cycle SHALL win and leave OVF=1.
REQ-023 The FSM SHALL have states ARM, IDLE, ACTIVE and TOUT.
REQ-024 ARM SHALL be entered on reset, last SYNC_STAGES+1 cycles, and suppress event detection so that a high T at reset release is not counted.
REQ-025 ARM SHALL then go to IDLE.
REQ-026 IDLE SHALL go to ACTIVE on the first accepted event.
REQ-027 In ACTIVE, a 16-bit idle timer SHALL clear on every accepted event and otherwise increment.
REQ-028 ACTIVE SHALL go to TOUT when the idle timer reaches TIMEOUT_CYC.
REQ-029 TIMEOUT SHALL equal 1 exactly while in TOUT.
REQ-030 In TOUT, an accepted event SHALL return the FSM to ACTIVE with the timer cleared; TIMEOUT SHALL drop in the same cycle PULSE is high.
REQ-031 Events SHALL be detected at a rate of up to one per clock (T toggling slower than CLK/2 after synchronization); every synchronized change SHALL count as exactly one event.

Reset
REQ-032 While RST=1, PULSE, EVT_VALID, PEND, OVF and TIMEOUT SHALL all be 0, the synchronizer and REF SHALL be 0, the FSM SHALL be in ARM, and the timer SHALL be 0.
REQ-033 Reset assertion SHALL take effect immediately, without a clock.
REQ-034 Reset asserted mid-operation SHALL discard all pending events and OVF.
REQ-035 Deassertion SHALL be synchronous to the following CLK edge.

Verification
REQ-036 Scenario: hold T=1 through reset release, EN=1 -> no PULSE, PEND=0, FSM reaches IDLE after 3 cycles.
REQ-037 Scenario: 5 toggles spaced 4 cycles, EVT_READY=0 -> 5 single-cycle PULSEs, each 3 edges after its toggle, PEND=5, EVT_VALID=1.
REQ-038 Scenario: 17 toggles with EVT_READY=0 -> PEND=15 and OVF=1; then CLR_OVF one cycle -> OVF=0, PEND=15.
REQ-039 Scenario: PEND=15 with a toggle arriving while EVT_READY=1 -> PEND stays 15, OVF stays 0; then drain 15 pops -> PEND=0, EVT_VALID=0.
REQ-040 Scenario: TIMEOUT_CYC=10, one toggle then silence -> TIMEOUT=1 exactly 10 cycles after the PULSE; next toggle -> TIMEOUT=0 with the PULSE.
REQ-041 Scenario: EN=0 during 3 toggles, then EN=1 -> no PULSE and PEND unchanged; a subsequent toggle counts once; RST pulsed mid-stream -> all outputs 0 immediately.
